// File: rtl/conf_loader.sv
// rtl/conf_loader.sv - streams config words into N_RC register files, RC-fastest order (optional checksum: CONF_LOADER_CHECKSUM_EN)
module conf_loader #(
    parameter int N_RC              = 4,
    parameter int INSTR_WIDTH       = 32,
    parameter int RCS_NUM_CREG      = 32,
    parameter int RCS_NUM_CREG_LOG2 = $clog2(RCS_NUM_CREG)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         load_start_i,
    input  logic [RCS_NUM_CREG_LOG2-1:0] load_base_i,
    input  logic [RCS_NUM_CREG_LOG2:0]   load_len_i,
    input  logic                         load_abort_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [INSTR_WIDTH-1:0]       cfg_data_i,
    output logic [INSTR_WIDTH-1:0]       instr_o,
    output logic [RCS_NUM_CREG_LOG2-1:0] pc_o,
    output logic [N_RC-1:0]              we_o,
    output logic                         ce_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         err_o
);

    localparam int RC_W = (N_RC > 1) ? $clog2(N_RC) : 1;

`ifdef CONF_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
`endif

    state_t                         state_q, state_d;
    logic [RCS_NUM_CREG_LOG2-1:0]   pc_cnt_q;
    logic [RC_W-1:0]                rc_cnt_q;
    logic [RCS_NUM_CREG_LOG2:0]     remaining_q;
    logic                           active;
    logic                           word_accept;
    logic                           rc_last;
    logic                           last_word;
    logic [RCS_NUM_CREG_LOG2-1:0]   pc_next;

    always_comb begin
        active = (state_q == S_LOAD);
`ifdef CONF_LOADER_CHECKSUM_EN
        active = active || (state_q == S_CHECK);
`endif
    end

    // An aborting cycle refuses the word so it can never be written.
    assign cfg_ready_o = active && !load_abort_i;
    assign busy_o      = active;
    assign done_o      = (state_q == S_DONE);
    assign word_accept = cfg_valid_i && cfg_ready_o;
    assign rc_last     = (rc_cnt_q == RC_W'(N_RC - 1));
    assign last_word   = rc_last && (remaining_q == (RCS_NUM_CREG_LOG2 + 1)'(1));
    assign pc_next     = (pc_cnt_q == RCS_NUM_CREG_LOG2'(RCS_NUM_CREG - 1)) ? '0 : pc_cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start_i) state_d = (load_len_i == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                if (load_abort_i) begin
                    state_d = S_IDLE;
                end else if (word_accept && last_word) begin
`ifdef CONF_LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef CONF_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (load_abort_i)     state_d = S_IDLE;
                else if (word_accept) state_d = S_DONE;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_cnt_q    <= '0;
            rc_cnt_q    <= '0;
            remaining_q <= '0;
            instr_o     <= '0;
            pc_o        <= '0;
            we_o        <= '0;
            ce_o        <= 1'b0;
        end else begin
            we_o <= '0;
            ce_o <= 1'b0;
            if (state_q == S_IDLE && load_start_i) begin
                pc_cnt_q    <= load_base_i;
                rc_cnt_q    <= '0;
                remaining_q <= load_len_i;
            end
            if (state_q == S_LOAD && word_accept) begin
                instr_o <= cfg_data_i;
                pc_o    <= pc_cnt_q;
                we_o    <= N_RC'(1) << rc_cnt_q;
                ce_o    <= 1'b1;
                if (rc_last) begin
                    rc_cnt_q    <= '0;
                    pc_cnt_q    <= pc_next;
                    remaining_q <= remaining_q - 1'b1;
                end else begin
                    rc_cnt_q <= rc_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef CONF_LOADER_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] xor_q;
    logic                   err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xor_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && load_start_i) begin
                xor_q <= '0;
                err_q <= 1'b0;
            end
            if (state_q == S_LOAD && word_accept) xor_q <= xor_q ^ cfg_data_i;
            if (state_q == S_CHECK && word_accept && cfg_data_i != xor_q) err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conf_loader.sv
// tb/tb_conf_loader.sv - randomized self-checking bench for conf_loader against a queue-based write model
module tb_conf_loader;

    localparam int N_RC = 4;
    localparam int IW   = 32;
    localparam int NC   = 32;
    localparam int LW   = 5;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          load_start_i;
    logic [LW-1:0] load_base_i;
    logic [LW:0]   load_len_i;
    logic          load_abort_i;
    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [IW-1:0] cfg_data_i;
    logic [IW-1:0] instr_o;
    logic [LW-1:0] pc_o;
    logic [N_RC-1:0] we_o;
    logic          ce_o;
    logic          busy_o;
    logic          done_o;
    logic          err_o;

    conf_loader #(.N_RC(N_RC), .INSTR_WIDTH(IW), .RCS_NUM_CREG(NC)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .load_start_i(load_start_i), .load_base_i(load_base_i), .load_len_i(load_len_i),
        .load_abort_i(load_abort_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_data_i(cfg_data_i),
        .instr_o(instr_o), .pc_o(pc_o), .we_o(we_o), .ce_o(ce_o),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    logic exp_err = 1'b0;

    logic [LW-1:0]   obs_pc[$],  exp_pc[$];
    logic [N_RC-1:0] obs_we[$],  exp_we[$];
    logic [IW-1:0]   obs_d[$],   exp_d[$];
    logic            obs_ce[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (we_o != '0 || ce_o) begin
            obs_pc.push_back(pc_o);
            obs_we.push_back(we_o);
            obs_d.push_back(instr_o);
            obs_ce.push_back(ce_o);
        end
        if (done_o) done_cnt++;
    end

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_we"}, we_o, 0);
        check_eq({tag, "_ce"}, ce_o, 0);
        check_eq({tag, "_instr"}, instr_o, 0);
        check_eq({tag, "_pc"}, pc_o, 0);
        check_eq({tag, "_busy"}, busy_o, 0);
        check_eq({tag, "_done"}, done_o, 0);
        check_eq({tag, "_err"}, err_o, 0);
        check_eq({tag, "_ready"}, cfg_ready_o, 0);
    endtask

    task automatic compare_writes(input string tag);
        int n;
        check_eq({tag, "_nwrites"}, obs_we.size(), exp_we.size());
        n = (obs_we.size() < exp_we.size()) ? obs_we.size() : exp_we.size();
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_pc"}, obs_pc[i], exp_pc[i]);
            check_eq({tag, "_we"}, obs_we[i], exp_we[i]);
            check_eq({tag, "_instr"}, obs_d[i], exp_d[i]);
            check_eq({tag, "_ce"}, obs_ce[i], 1);
        end
        obs_pc.delete(); obs_we.delete(); obs_d.delete(); obs_ce.delete();
        exp_pc.delete(); exp_we.delete(); exp_d.delete();
    endtask

    // One load from start to completion/abort/reset; expected writes are derived from base, len and word index.
    task automatic run_load(input string tag, input int base, input int len, input int abort_at,
                            input int reset_at, input int stall_pct, input bit bad_sum,
                            input bit noise, input bit seq);
        int n, done0;
        bit cut;
        logic [IW-1:0] sum, w;
        n = len * N_RC;
        cut = 0;
        sum = '0;
        obs_pc.delete(); obs_we.delete(); obs_d.delete(); obs_ce.delete();
        done0 = done_cnt;
        load_base_i  = base[LW-1:0];
        load_len_i   = len[LW:0];
        load_start_i = 1'b1;
        @(negedge clk_i);
        load_start_i = 1'b0;
        exp_err = 1'b0;
        check_eq({tag, "_start_err"}, err_o, 0);
        if (len == 0) begin
            check_eq({tag, "_len0_done"}, done_o, 1);
            check_eq({tag, "_len0_busy"}, busy_o, 0);
            @(negedge clk_i);
            check_eq({tag, "_len0_done_off"}, done_o, 0);
        end else begin
            check_eq({tag, "_busy"}, busy_o, 1);
            check_eq({tag, "_done_early"}, done_o, 0);
            for (int k = 0; k < n && !cut; k++) begin
                while ($urandom_range(99) < stall_pct) begin
                    cfg_valid_i = 1'b0;
                    cfg_data_i  = $urandom;
                    if (noise) begin
                        load_start_i = 1'($urandom_range(1));
                        load_base_i  = LW'($urandom);
                        load_len_i   = (LW + 1)'($urandom_range(0, 32));
                    end
                    @(negedge clk_i);
                    load_start_i = 1'b0;
                end
                if (k == reset_at) begin
                    rst_i       = 1'b1;
                    cfg_valid_i = 1'b0;
                    @(negedge clk_i);
                    check_all_zero({tag, "_midrst"});
                    rst_i   = 1'b0;
                    exp_err = 1'b0;
                    cut     = 1;
                end else begin
                    w = seq ? IW'(k + 1) : IW'($urandom);
                    cfg_valid_i = 1'b1;
                    cfg_data_i  = w;
                    if (k == abort_at) begin
                        load_abort_i = 1'b1;
                        #1 check_eq({tag, "_abort_ready"}, cfg_ready_o, 0);
                        @(negedge clk_i);
                        load_abort_i = 1'b0;
                        cfg_valid_i  = 1'b0;
                        check_eq({tag, "_abort_busy"}, busy_o, 0);
                        check_eq({tag, "_abort_done"}, done_o, 0);
                        cut = 1;
                    end else begin
                        #1 check_eq({tag, "_ready"}, cfg_ready_o, 1);
                        exp_pc.push_back(LW'((base + k / N_RC) % NC));
                        exp_we.push_back(N_RC'(1 << (k % N_RC)));
                        exp_d.push_back(w);
                        sum = sum ^ w;
                        @(negedge clk_i);
                        cfg_valid_i = 1'b0;
                    end
                end
            end
            if (!cut) begin
`ifdef CONF_LOADER_CHECKSUM_EN
                while ($urandom_range(99) < stall_pct) @(negedge clk_i);
                cfg_valid_i = 1'b1;
                cfg_data_i  = sum ^ IW'(bad_sum);
                #1 check_eq({tag, "_chk_ready"}, cfg_ready_o, 1);
                @(negedge clk_i);
                cfg_valid_i = 1'b0;
                exp_err = bad_sum;
`endif
                check_eq({tag, "_done"}, done_o, 1);
                check_eq({tag, "_done_busy"}, busy_o, 0);
                check_eq({tag, "_err"}, err_o, exp_err);
                @(negedge clk_i);
                check_eq({tag, "_done_off"}, done_o, 0);
                check_eq({tag, "_idle_ready"}, cfg_ready_o, 0);
            end
        end
        repeat (2) @(negedge clk_i);
        compare_writes(tag);
        check_eq({tag, "_ndone"}, done_cnt - done0, cut ? 0 : 1);
        check_eq({tag, "_err_after"}, err_o, exp_err);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, base, ab, rs, n;
        rst_i = 1'b1; load_start_i = 1'b0; load_base_i = '0; load_len_i = '0;
        load_abort_i = 1'b0; cfg_valid_i = 1'b0; cfg_data_i = '0;
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_i);
        check_all_zero("post_reset");
        load_abort_i = 1'b1;
        @(negedge clk_i);
        load_abort_i = 1'b0;
        check_eq("idle_abort_busy", busy_o, 0);
        check_eq("idle_abort_done", done_o, 0);

        run_load("basic",    0, 2, -1, -1, 0,  0, 0, 1);
        run_load("wrap",     31, 2, -1, -1, 0, 0, 0, 0);
        run_load("toggle",   0, 2, -1, -1, 50, 0, 0, 1);
        run_load("abort3",   0, 2, 2, -1, 0,  0, 0, 0);
        run_load("after_ab", 5, 1, -1, -1, 0, 0, 0, 0);
        run_load("len0",     3, 0, -1, -1, 0, 0, 0, 0);
        run_load("midrst",   7, 3, -1, 3, 20, 0, 0, 0);
`ifdef CONF_LOADER_CHECKSUM_EN
        run_load("sum_ok",   0, 1, -1, -1, 0, 0, 0, 1);
        run_load("sum_bad",  0, 1, -1, -1, 0, 1, 0, 1);
        repeat (5) @(negedge clk_i);
        check_eq("sum_sticky", err_o, 1);
        run_load("sum_clear", 9, 1, -1, -1, 0, 0, 0, 0);
`endif

        for (int it = 0; it < 30; it++) begin
            len  = ($urandom_range(9) == 0) ? 32 : int'($urandom_range(0, 6));
            base = $urandom_range(0, NC - 1);
            n    = len * N_RC;
            ab   = -1;
            rs   = -1;
            if (n > 0 && $urandom_range(99) < 15)     ab = $urandom_range(0, n - 1);
            else if (n > 0 && $urandom_range(99) < 6) rs = $urandom_range(0, n - 1);
            run_load("rand", base, len, ab, rs, $urandom_range(0, 60),
                     1'($urandom_range(1)), 1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
